// File: rtl/g_4evt_latch_if.sv
// Event sources, mask/clear controls and flag/status outputs of the g_4evt_latch capture stage.
interface g_4evt_latch_if;
  logic       A, B, C, D;
  logic [3:0] MASK;
  logic [3:0] CLR;
  logic       QA, QB, QC, QD;
  logic [3:0] OVF;
  logic [3:0] EVT;
  logic       RDY;

  modport master (output A, B, C, D, MASK, CLR,
                  input  QA, QB, QC, QD, OVF, EVT, RDY);
  modport slave  (input  A, B, C, D, MASK, CLR,
                  output QA, QB, QC, QD, OVF, EVT, RDY);
endinterface

// File: rtl/g_4evt_latch.sv
// Four-channel sync + edge-detect + sticky flag stage feeding g_4or; flag/EVT visible SYNC_STAGES edges
// after the input settles; no backpressure, CLR is a level and a same-cycle capture always wins over it.
module g_4evt_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 0
) (
  input  logic           CLK,
  input  logic           RSTN,
  g_4evt_latch_if.slave  bus
);

  localparam logic [2:0] CNT_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] in_w, s_w, prev_q, edge_w, cap_w;
  logic [3:0] flag_q, flag_d, ovf_q, ovf_d, evt_q;
  logic [2:0] cnt_q, cnt_d;
  logic       rdy_w;

  assign in_w  = {bus.D, bus.C, bus.B, bus.A};
  assign s_w   = sync_q[SYNC_STAGES-1];
  assign rdy_w = (cnt_q == CNT_MAX);
  assign cnt_d = rdy_w ? cnt_q : cnt_q + 3'd1;

  always_comb begin
    case (EDGE)
      1:       edge_w = ~s_w & prev_q;
      2:       edge_w = s_w ^ prev_q;
      default: edge_w = s_w & ~prev_q;
    endcase
  end

  // Warm-up gate hides the edge an input already high at reset release would otherwise produce.
  assign cap_w = edge_w & ~bus.MASK & {4{rdy_w}};

  always_comb begin
    flag_d = flag_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_w[i] && bus.CLR[i]) begin
        flag_d[i] = 1'b1;
        ovf_d[i]  = 1'b0;
      end else if (cap_w[i] && flag_q[i]) begin
        ovf_d[i]  = 1'b1;
      end else if (cap_w[i]) begin
        flag_d[i] = 1'b1;
      end else if (bus.CLR[i]) begin
        flag_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= '0;
      prev_q <= '0;
      flag_q <= '0;
      ovf_q  <= '0;
      evt_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_w};
      prev_q <= s_w;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      evt_q  <= cap_w;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.QA  = flag_q[0];
  assign bus.QB  = flag_q[1];
  assign bus.QC  = flag_q[2];
  assign bus.QD  = flag_q[3];
  assign bus.OVF = ovf_q;
  assign bus.EVT = evt_q;
  assign bus.RDY = rdy_w;

endmodule

// File: doc/g_4evt_latch.md
Name: g_4evt_latch

Overview:
- Four-channel event capture stage that sits directly upstream of the g_4or macro.
- Each channel synchronises an asynchronous input, detects the selected edge and holds a sticky flag until software clears it.
- The four flags QA..QD drive the A..D inputs of g_4or, whose Y output becomes the aggregated interrupt.
- Per-channel mask, clear and overflow reporting are provided.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per channel; legal values 2..3.
- EDGE, 0, edge selection: 0 = rising, 1 = falling, 2 = both; applies to all channels.

Ports:
- CLK  input  1  single clock; all state is updated on its rising edge.
- RSTN  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to CLK externally.
- A  input  1  channel 0 event source, asynchronous to CLK.
- B  input  1  channel 1 event source, asynchronous.
- C  input  1  channel 2 event source, asynchronous.
- D  input  1  channel 3 event source, asynchronous.
- MASK  input  4  per-channel mask, bit0 = A; 1 blocks new captures on that channel.
- CLR  input  4  per-channel synchronous clear of the flag and overflow, 1-cycle pulse or level.
- QA, QB, QC, QD  output  1 each  sticky event flags; these feed g_4or A..D.
- OVF  output  4  per-channel overflow: a capture occurred while the flag was already set.
- EVT  output  4  registered 1-cycle strobe per channel on each detected, unmasked edge.
- RDY  output  1  high once the post-reset warm-up has completed.

Behaviour:
- Reset (RSTN=0) forces:
  - all synchroniser stages and the previous-sample register to 0;
  - QA..QD, OVF, EVT and RDY to 0;
  - the warm-up counter to 0.
- Synchroniser: SYNC_STAGES flops per channel, with no logic between stages. s = last stage. p = previous-sample register, and p <= s every cycle.
- Edge detect (combinational):
  - EDGE=0: e = s & ~p.
  - EDGE=1: e = ~s & p.
  - EDGE=2: e = s ^ p.
- Warm-up:
  - A counter counts 0..SYNC_STAGES+1 after reset release, then saturates. RDY = 1 when saturated.
  - While RDY=0, e is forced to 0. This prevents a spurious capture from an input already high at reset release.
- Capture: cap[i] = e[i] & ~MASK[i] & RDY.
- Per-channel register update, in priority order:
  - cap=1 and CLR=1: flag <= 1, OVF <= 0. The set wins, so no event is lost.
  - cap=1 and flag=1: OVF <= 1, and the flag stays 1.
  - cap=1: flag <= 1.
  - CLR=1: flag <= 0, OVF <= 0.
  - Otherwise: hold.
- EVT[i] <= cap[i] every cycle, so it is a single-cycle strobe.
- MASK does not clear an existing flag; it only blocks new captures. Unmasking does not retro-capture edges that occurred while masked.
- Latency: an input stable across rising edge k produces a visible flag and EVT after rising edge k+SYNC_STAGES (2 cycles at the default).
- Pulse width: input pulses shorter than one CLK period may be missed and are not guaranteed. Pulses of at least 2 periods are always captured.
- Back-to-back edges: captures on consecutive cycles (EDGE=2 with a toggling input) each produce an EVT. The second capture sets OVF if no CLR intervened.
- Reset mid-operation: all state clears immediately. Warm-up restarts on release, and a flag lost to reset is not recovered.
- Channels are fully independent; there is no cross-channel priority.

Test Plan:
1. Default parameters; after RDY=1, raise B at edge k → EVT=4'b0010 for exactly 1 cycle after edge k+2; QB=1 and stays 1; QA, QC, QD stay 0.
2. With QB=1, pulse CLR=4'b0010 for one cycle → QB=0 on the next edge; OVF[1] stays 0.
3. With QA=1, produce a second rising edge on A → OVF=4'b0001 and QA stays 1. Then CLR[0]=1 → QA=0 and OVF=0.
4. MASK=4'b0100 and raise C → no EVT and QC=0. Clear MASK while C is high → still no capture. Drop and re-raise C → QC=1.
5. Hold A=1 through reset release → RDY rises 3 cycles after release; no capture; QA=0.
6. Edge detected on D in the same cycle CLR[3]=1 (with QD=1) → QD stays 1 and OVF[3]=0.
7. Assert RSTN=0 mid-stream with flags set → all outputs 0 immediately, independent of CLK.
8. Repeat with EDGE=2 and a toggling input: every transition is captured with 2-cycle latency.
